hold_pulse_gen: RTL and testbench



---
 rtl/lock_pkg.sv | 13 +
 rtl/sec_tick_counter.sv | 31 +++
 rtl/hold_pulse_gen.sv | 139 +++++++++++++
 tb/tb_hold_pulse_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and defaults for the door-lock control blocks.
package lock_pkg;

  // Tick rate of the lock's ms-rate system clock.
  localparam int DEFAULT_CLK_HZ = 1000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2
  } hold_state_t;

endpackage

// File: rtl/sec_tick_counter.sv
// Sub-second counter: counts 0..CLK_HZ-1 while enabled and emits a
// one-cycle tick on the cycle it wraps back to 0.
module sec_tick_counter #(
  parameter int CLK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_HZ) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;

  // Sub-counter: clear has priority, wraps at CLK_HZ-1, holds when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = en & ~clear & (cnt_q == LAST);

endmodule

// File: rtl/hold_pulse_gen.sv
// Timed actuator drive: a one-cycle start holds pulse_out high for exactly
// HOLD_S seconds, then a COOLDOWN_CYC-cycle cooldown blocks new requests.
// Optional macro HOLD_PULSE_RETRIGGER_EN: start during a hold restarts it.
//
// state    | meaning
// IDLE     | waiting for start, all outputs low
// ACTIVE   | pulse_out high, seconds counting down
// COOLDOWN | actuator off, busy, start/abort ignored
module hold_pulse_gen
  import lock_pkg::*;
#(
  parameter int HOLD_S       = 5,
  parameter int CLK_HZ       = DEFAULT_CLK_HZ,
  parameter int COOLDOWN_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       pulse_out,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [7:0] remaining_s
);

  localparam int SW  = $clog2(HOLD_S) + 1;
  localparam int CDW = $clog2(COOLDOWN_CYC) + 1;
  localparam logic [SW-1:0]  SEC_LOAD = SW'(HOLD_S);
  localparam logic [SW-1:0]  SEC_ONE  = SW'(1);
  localparam logic [CDW-1:0] CD_LOAD  = CDW'(COOLDOWN_CYC);
  localparam logic [CDW-1:0] CD_ONE   = CDW'(1);
  // A zero-length cooldown goes straight back to IDLE.
  localparam hold_state_t AFTER_HOLD = (COOLDOWN_CYC == 0) ? IDLE : COOLDOWN;

  hold_state_t    state_q, state_d;
  logic [SW-1:0]  sec_q, sec_d;
  logic [CDW-1:0] cd_q, cd_d;
  logic           sec_tick;
  logic           retrig;
  logic           last_cycle;
  logic           pulse_d, busy_d, done_d, aborted_d;
  logic [7:0]     rem_d;

`ifdef HOLD_PULSE_RETRIGGER_EN
  assign retrig = (state_q == ACTIVE) & start & ~abort;
`else
  assign retrig = 1'b0;
`endif

  sec_tick_counter #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear ((state_q != ACTIVE) | retrig | abort),
    .en    (state_q == ACTIVE),
    .tick  (sec_tick)
  );

  assign last_cycle = sec_tick & (sec_q == SEC_ONE);

  // State register plus seconds and cooldown down-counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sec_q   <= '0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      cd_q    <= cd_d;
    end
  end

  // Next-state and counter update; abort beats start and completion.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    cd_d    = cd_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ACTIVE;
          sec_d   = SEC_LOAD;
        end
      end
      ACTIVE: begin
        if (abort || (!retrig && last_cycle)) begin
          state_d = AFTER_HOLD;
          sec_d   = '0;
          cd_d    = CD_LOAD;
        end else if (retrig) begin
          sec_d = SEC_LOAD;
        end else if (sec_tick) begin
          sec_d = sec_q - SEC_ONE;
        end
      end
      COOLDOWN: begin
        if (cd_q == CD_ONE || cd_q == '0) begin
          state_d = IDLE;
          cd_d    = '0;
        end else begin
          cd_d = cd_q - CD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        sec_d   = '0;
        cd_d    = '0;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    pulse_d   = (state_d == ACTIVE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == ACTIVE) & ~abort & ~retrig & last_cycle;
    aborted_d = (state_q == ACTIVE) & abort;
    rem_d     = (state_d == ACTIVE) ? 8'(sec_d) : 8'd0;
  end

  // Output register; reset drops the actuator without any strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      remaining_s <= 8'd0;
    end else begin
      pulse_out   <= pulse_d;
      busy        <= busy_d;
      done        <= done_d;
      aborted     <= aborted_d;
      remaining_s <= rem_d;
    end
  end

endmodule

// File: tb/tb_hold_pulse_gen.sv
// Scoreboard bench for hold_pulse_gen (HOLD_S=2, CLK_HZ=10): one instance
// with COOLDOWN_CYC=5 and one with COOLDOWN_CYC=0 share the stimulus.
module tb_hold_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       p5, b5, d5, a5;
  logic [7:0] r5;
  logic       p0, b0, d0, a0;
  logic [7:0] r0;

  int    checks = 0;
  int    errors = 0;
  int    gcyc   = 0;
  bit    sel    = 1'b0;
  string cur_case = "reset";

  typedef struct {
    int         cyc;
    logic       p;
    logic       b;
    logic [7:0] r;
  } lvl_t;
  typedef struct {
    int cyc;
    int kind;
  } stb_t;

  lvl_t lvl_q[$];
  stb_t stb_q[$];

  int s_c[$], ab_c[$], p_lo[$], p_hi[$], r_lo[$], r_hi[$], b_lo[$], b_hi[$], d_c[$], a_c[$];

  hold_pulse_gen #(.HOLD_S(2), .CLK_HZ(10), .COOLDOWN_CYC(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pulse_out(p5), .busy(b5), .done(d5), .aborted(a5), .remaining_s(r5)
  );

  hold_pulse_gen #(.HOLD_S(2), .CLK_HZ(10), .COOLDOWN_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pulse_out(p0), .busy(b0), .done(d0), .aborted(a0), .remaining_s(r0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) gcyc <= gcyc + 1;

  function automatic bit in_rng(input int k, input int lo[$], input int hi[$]);
    foreach (lo[i]) if (k >= lo[i] && k <= hi[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_list(input int k, input int q[$]);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: levels are compared every cycle an expectation is queued,
  // strobes are compared whenever the selected DUT raises one.
  always @(negedge clk) begin
    logic       mp, mb, md, ma;
    logic [7:0] mr;
    lvl_t       e;
    stb_t       s;
    #1;
    mp = sel ? p0 : p5;
    mb = sel ? b0 : b5;
    md = sel ? d0 : d5;
    ma = sel ? a0 : a5;
    mr = sel ? r0 : r5;
    if (lvl_q.size() > 0) begin
      e = lvl_q.pop_front();
      checks++;
      if (e.cyc != gcyc || mp !== e.p || mb !== e.b || mr !== e.r) begin
        errors++;
        $display("FAIL %s levels cyc %0d: got pulse=%0b busy=%0b rem=%0d, want pulse=%0b busy=%0b rem=%0d (exp cyc %0d)",
                 cur_case, gcyc, mp, mb, mr, e.p, e.b, e.r, e.cyc);
      end
    end
    if (md === 1'b1 || ma === 1'b1) begin
      checks++;
      if (md === 1'b1 && ma === 1'b1) begin
        errors++;
        $display("FAIL %s both_strobes cyc %0d: got done=1 aborted=1, want at most one", cur_case, gcyc);
      end else if (stb_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected_strobe cyc %0d: got done=%0b aborted=%0b, want none", cur_case, gcyc, md, ma);
      end else begin
        s = stb_q.pop_front();
        if (s.cyc != gcyc || s.kind != (ma ? 1 : 0)) begin
          errors++;
          $display("FAIL %s strobe: got %s at cyc %0d, want %s at cyc %0d", cur_case,
                   ma ? "aborted" : "done", gcyc, s.kind ? "aborted" : "done", s.cyc);
        end
      end
    end
  end

  task automatic clr_all();
    s_c.delete(); ab_c.delete(); p_lo.delete(); p_hi.delete(); r_lo.delete(); r_hi.delete();
    b_lo.delete(); b_hi.delete(); d_c.delete(); a_c.delete();
  endtask

  task automatic check_all_zero(input string what, input logic [11:0] got);
    checks++;
    if (got !== 12'd0) begin
      errors++;
      $display("FAIL %s: got {pulse,busy,done,aborted,rem}=%03h, want 000", what, got);
    end
  endtask

  // Driver: applies start/abort per cycle and queues the hand-derived
  // expectations; rst_at >= 0 asserts rst_n mid-cycle at that cycle.
  task automatic run_case(input string name, input int len, input int rst_at, input bit use0);
    int   base;
    lvl_t e;
    stb_t s;
    bit   rst_done = 1'b0;
    @(negedge clk);
    cur_case = name;
    sel = use0;
    base = gcyc;
    foreach (d_c[i]) begin s.cyc = base + d_c[i]; s.kind = 0; stb_q.push_back(s); end
    foreach (a_c[i]) begin s.cyc = base + a_c[i]; s.kind = 1; stb_q.push_back(s); end
    for (int k = 0; k < len; k++) begin
      if (k != 0) @(negedge clk);
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        check_all_zero({name, " async_reset dut"}, {p5, b5, d5, a5, r5});
        check_all_zero({name, " async_reset dut0"}, {p0, b0, d0, a0, r0});
        rst_done = 1'b1;
        break;
      end
      start = in_list(k, s_c);
      abort = in_list(k, ab_c);
      e.cyc = base + k;
      e.p   = in_rng(k, p_lo, p_hi);
      e.b   = in_rng(k, b_lo, b_hi);
      e.r   = in_rng(k, r_lo, r_hi) ? 8'd2 : (e.p ? 8'd1 : 8'd0);
      lvl_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    if (rst_done) rst_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      if (g != 0) @(negedge clk);
      e.cyc = gcyc; e.p = 1'b0; e.b = 1'b0; e.r = 8'd0;
      lvl_q.push_back(e);
    end
    @(negedge clk);
    #2;
    checks++;
    if (stb_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_strobes: got %0d outstanding, want 0", name, stb_q.size());
    end
    stb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #3;
    check_all_zero("reset dut", {p5, b5, d5, a5, r5});
    check_all_zero("reset dut0", {p0, b0, d0, a0, r0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Normal hold, start during cooldown ignored, restart right after.
    clr_all();
    s_c = '{0, 22, 26};
    p_lo = '{1, 27};  p_hi = '{20, 46};
    r_lo = '{1, 27};  r_hi = '{10, 36};
    b_lo = '{1, 27};  b_hi = '{25, 51};
    d_c = '{21, 47};
    run_case("hold_cooldown", 56, -1, 1'b0);

    // Abort part-way through the hold.
    clr_all();
    s_c = '{0};  ab_c = '{7};
    p_lo = '{1};  p_hi = '{7};
    r_lo = '{1};  r_hi = '{7};
    b_lo = '{1};  b_hi = '{12};
    a_c = '{8};
    run_case("abort", 16, -1, 1'b0);

    // Start and abort together in IDLE: nothing happens.
    clr_all();
    s_c = '{0};  ab_c = '{0};
    run_case("start_abort_idle", 6, -1, 1'b0);

    // Reset asserted in cycle 10 of a hold.
    clr_all();
    s_c = '{0};
    p_lo = '{1};  p_hi = '{9};
    r_lo = '{1};  r_hi = '{9};
    b_lo = '{1};  b_hi = '{9};
    run_case("reset_mid_hold", 11, 10, 1'b0);

    // Zero cooldown: back-to-back holds.
    clr_all();
    s_c = '{0, 21};
    p_lo = '{1, 22};  p_hi = '{20, 41};
    r_lo = '{1, 22};  r_hi = '{10, 31};
    b_lo = '{1, 22};  b_hi = '{20, 41};
    d_c = '{21, 42};
    run_case("no_cooldown", 45, -1, 1'b1);

    // Second start during ACTIVE.
    clr_all();
    s_c = '{0, 15};
`ifdef HOLD_PULSE_RETRIGGER_EN
    p_lo = '{1};  p_hi = '{35};
    r_lo = '{1, 16};  r_hi = '{10, 25};
    b_lo = '{1};  b_hi = '{40};
    d_c = '{36};
`else
    p_lo = '{1};  p_hi = '{20};
    r_lo = '{1};  r_hi = '{10};
    b_lo = '{1};  b_hi = '{25};
    d_c = '{21};
`endif
    run_case("start_in_active", 45, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
